// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: buffers ALU commands in a FIFO, issues them one at a time and returns tagged results
// Ports: cmd_* valid/ready command stream in; alu_a/alu_b/alu_op registered drive to the ALU,
// alu_out its combinational result; rsp_* valid/ready tagged response stream out; busy = work pending.
module alu_cmd_driver #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int OUT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic [3:0]            cmd_tag,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [3:0]            alu_op,
    input  logic [OUT_WIDTH-1:0]  alu_out,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [OUT_WIDTH-1:0]  rsp_result,
    output logic [3:0]            rsp_tag,
    output logic                  rsp_err,
    output logic                  busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 * DATA_WIDTH + 8;
    localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t                  state_q, state_d;
    logic [EW-1:0]           fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]             count_q, count_d;
    logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]              alu_op_q, alu_op_d, tag_q, tag_d, rsp_tag_q, rsp_tag_d;
    logic                    err_q, err_d, ones_q, ones_d;
    logic                    rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, busy_q, busy_d;
    logic [OUT_WIDTH-1:0]    rsp_result_q, rsp_result_d;
    logic [3:0]              h_op, h_tag;
    logic [DATA_WIDTH-1:0]   h_a, h_b;
    logic                    push, pop, h_ill, h_dz;
    assign {h_op, h_a, h_b, h_tag} = fifo_mem[rd_ptr_q];
    // Full-ness looks only at the registered count: a same-cycle pop never admits a push when full.
    assign cmd_ready  = rst_n && count_q != FULL;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    always_comb begin
        push         = cmd_valid && cmd_ready;
        pop          = count_q != '0 && (state_q == IDLE || (state_q == RESP && rsp_ready));
        h_ill        = h_op > 4'd10;
        h_dz         = h_op == 4'd4 && h_b == '0;
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        count_d      = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
        state_d      = pop ? ISSUE : state_q == ISSUE ? RESP : (state_q == RESP && rsp_ready) ? IDLE : state_q;
        // Rejected commands never reach the ALU as their real opcode; it sees NOP instead.
        alu_op_d     = pop ? ((h_ill || h_dz) ? 4'd0 : h_op) : (state_q == RESP && rsp_ready) ? 4'd0 : alu_op_q;
        alu_a_d      = pop ? h_a : alu_a_q;
        alu_b_d      = pop ? h_b : alu_b_q;
        tag_d        = pop ? h_tag : tag_q;
        err_d        = pop ? (h_ill || h_dz) : err_q;
        ones_d       = pop ? h_dz : ones_q;
        rsp_valid_d  = state_q == ISSUE || (rsp_valid_q && !rsp_ready);
        // Divide-by-zero reports all ones, illegal opcodes report zero.
        rsp_result_d = state_q == ISSUE ? (err_q ? {OUT_WIDTH{ones_q}} : alu_out) : rsp_result_q;
        rsp_tag_d    = state_q == ISSUE ? tag_q : rsp_tag_q;
        rsp_err_d    = state_q == ISSUE ? err_q : rsp_err_q;
        busy_d       = count_d != '0 || state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b, cmd_tag};
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            tag_q        <= '0;
            err_q        <= 1'b0;
            ones_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            tag_q        <= tag_d;
            err_q        <= err_d;
            ones_q       <= ones_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
        end
    end
endmodule
